// File: rtl/snake_pkg.sv
// Shared definitions for the snake game step path.
// Defaults for the tick receiver and its pending-count width.
package snake_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int STEP_MAX_PEND   = 7;

  function automatic int pend_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/step_tick_rx_if.sv
// Step request/acknowledge handshake between the tick receiver
// and the snake update logic.
interface step_tick_rx_if #(
  parameter int PEND_W = 3
);

  logic              step_req;
  logic              step_ack;
  logic [PEND_W-1:0] pend;

  modport master (
    output step_req,
    output pend,
    input  step_ack
  );

  modport slave (
    input  step_req,
    input  pend,
    output step_ack
  );

endinterface

// File: rtl/step_tick_rx_sync_rise_det.sv
// Synchronizes the slow tick into clk and emits a one-cycle rise.
// Stays quiet until the chain and prev hold post-reset samples.
module sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  output logic rise_o
);

  localparam int ARM_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              armed_q, armed_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;

  always_comb begin
    sync_d    = {sync_q[STAGES-2:0], tick_i};
    prev_d    = sync_q[STAGES-1];
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    // armed after STAGES+1 edges, once prev holds a real sample
    if (!armed_q) begin
      if (arm_cnt_q == ARM_W'(STAGES)) armed_d = 1'b1;
      else arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign rise_o = armed_q & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/step_tick_rx.sv
// Turns slow tick edges into queued step requests in the clk domain.
// Tracks pending steps, sticky overrun and a wrapping tick count.
module step_tick_rx
  import snake_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MAX_PEND    = STEP_MAX_PEND,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             clr_ovr,
  step_tick_rx_if.master   st,
  output logic             overrun,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam int PEND_W = pend_w(MAX_PEND);

  logic              rise_raw, rise, acc, req;
  logic              ovr_set;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_in),
    .rise_o (rise_raw)
  );

  assign rise = rise_raw & en;
  assign req  = (pend_q != '0);
  assign acc  = req & st.step_ack;

  always_comb begin
    pend_d  = pend_q;
    ovr_set = 1'b0;
    unique case (1'b1)
      rise & ~acc: begin
        if (pend_q < PEND_W'(MAX_PEND)) pend_d = pend_q + PEND_W'(1);
        else ovr_set = 1'b1;
      end
      ~rise & acc: pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
    // a new overrun wins over a same-cycle clear
    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
    cnt_d = cnt_q + CNT_W'(rise);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign st.step_req = req;
  assign st.pend     = pend_q;
  assign overrun     = ovr_q;
  assign tick_cnt    = cnt_q;

endmodule
